// File: rtl/wb_arbiter_rr.sv
// N-master to 1-slave pipelined Wishbone B4 arbiter, fixed-priority or round-robin; grant 1 cycle after request.
// Backpressure: losers and the granted master at the outstanding limit see stall; cyc drop releases combinationally.
module wb_arbiter_rr #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ARB_MODE        = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_wb_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wb_dat_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wb_dat_o,
  input  logic [NUM_MASTERS-1:0]            s_wb_we_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] s_wb_sel_i,
  input  logic [NUM_MASTERS-1:0]            s_wb_stb_i,
  input  logic [NUM_MASTERS-1:0]            s_wb_cyc_i,
  output logic [NUM_MASTERS-1:0]            s_wb_ack_o,
  output logic [NUM_MASTERS-1:0]            s_wb_stall_o,
  output logic [ADDR_WIDTH-1:0]             m_wb_adr_o,
  output logic [DATA_WIDTH-1:0]             m_wb_dat_o,
  input  logic [DATA_WIDTH-1:0]             m_wb_dat_i,
  output logic                              m_wb_we_o,
  output logic [(DATA_WIDTH/8)-1:0]         m_wb_sel_o,
  output logic                              m_wb_stb_o,
  output logic                              m_wb_cyc_o,
  input  logic                              m_wb_ack_i,
  input  logic                              m_wb_stall_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW        = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_gidx;
  logic [IW-1:0]          r_last;
  logic [CW-1:0]          r_outst;

  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_win_vld;
  logic [IW-1:0]          w_win_idx;
  logic [NUM_MASTERS-1:0] w_win_oh;
  logic [ADDR_WIDTH-1:0]  w_g_adr;
  logic [DATA_WIDTH-1:0]  w_g_dat;
  logic [SEL_WIDTH-1:0]   w_g_sel;
  logic                   w_g_we;
  logic                   w_g_cyc;
  logic                   w_g_stb;
  logic                   w_full;
  logic                   w_accept;
  logic                   w_ackd;

  assign w_req = s_wb_cyc_i & s_wb_stb_i;

  // Later matches overwrite earlier ones, so loops run from lowest to highest priority.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_win_oh  = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (w_req[i]) begin
          w_win_vld   = 1'b1;
          w_win_idx   = IW'(i);
          w_win_oh    = '0;
          w_win_oh[i] = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (w_req[i] && (((int'(r_last) + k) % NUM_MASTERS) == i)) begin
            w_win_vld   = 1'b1;
            w_win_idx   = IW'(i);
            w_win_oh    = '0;
            w_win_oh[i] = 1'b1;
          end
        end
      end
    end
  end

  // r_grant is zero outside GRANT, so the selected bus is all-zero when idle.
  always_comb begin
    w_g_adr = '0;
    w_g_dat = '0;
    w_g_sel = '0;
    w_g_we  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) begin
        w_g_adr = s_wb_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_g_dat = s_wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        w_g_sel = s_wb_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
        w_g_we  = s_wb_we_i[i];
      end
    end
  end

  assign w_g_cyc  = |(r_grant & s_wb_cyc_i);
  assign w_g_stb  = |(r_grant & s_wb_stb_i);
  assign w_full   = (r_outst == CW'(MAX_OUTSTANDING));

  assign m_wb_cyc_o = rst_i & (r_state == S_GRANT) & w_g_cyc;
  assign m_wb_stb_o = m_wb_cyc_o & w_g_stb & ~w_full;
  assign m_wb_adr_o = w_g_adr;
  assign m_wb_dat_o = w_g_dat;
  assign m_wb_sel_o = w_g_sel;
  assign m_wb_we_o  = w_g_we;
  assign grant_o    = r_grant;

  assign s_wb_stall_o = ~r_grant | {NUM_MASTERS{m_wb_stall_i | w_full}};
  assign s_wb_ack_o   = r_grant & {NUM_MASTERS{m_wb_ack_i}};

  always_comb begin
    s_wb_dat_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) s_wb_dat_o[i*DATA_WIDTH +: DATA_WIDTH] = m_wb_dat_i;
    end
  end

  assign w_accept = m_wb_stb_o & ~m_wb_stall_i;
  assign w_ackd   = m_wb_ack_i & (r_outst != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
      r_outst <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_outst <= '0;
          if (w_win_vld) begin
            r_grant <= w_win_oh;
            r_gidx  <= w_win_idx;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!w_g_cyc) begin
            r_last  <= r_gidx;
            r_outst <= '0;
            r_grant <= '0;
            r_state <= S_IDLE;
          end else if (w_accept && !w_ackd) begin
            r_outst <= r_outst + CW'(1);
          end else if (!w_accept && w_ackd) begin
            r_outst <= r_outst - CW'(1);
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
